bus_rr: RTL
===========

# bus_rr

Parametrised multi-host, multi-device simulation interconnect for the compliance and system testbenches. It arbitrates host requests onto address-decoded devices and tracks up to `MaxOutstanding` in-flight transactions, so devices with latency greater than one cycle can be used. Accesses to unmapped addresses return a bus error. It sits between the core/test-utility hosts and the RAM/peripheral devices.

## Interface
- `NrHosts`, 3: number of hosts; index 0 has highest fixed priority.
- `NrDevices`, 2: number of devices.
- `DataWidth`, 32: data bus width.
- `AddressWidth`, 32: address bus width.
- `MaxOutstanding`, 4: depth of the response-tracking FIFO; must be ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `host_req_i`  in  NrHosts  request per host.
- `host_gnt_o`  out  NrHosts  grant; one-hot or zero.
- `host_addr_i`  in  NrHosts×AddressWidth  address.
- `host_we_i`  in  NrHosts  write enable.
- `host_be_i`  in  NrHosts×DataWidth/8  byte enables.
- `host_wdata_i`  in  NrHosts×DataWidth  write data.
- `host_rvalid_o`  out  NrHosts  response valid.
- `host_rdata_o`  out  NrHosts×DataWidth  read data, broadcast to all hosts.
- `host_err_o`  out  NrHosts  error, qualified by `host_rvalid_o`.
- `device_req_o`  out  NrDevices  request per device.
- `device_addr_o`, `device_we_o`, `device_be_o`, `device_wdata_o`  out  per device  forwarded from the granted host.
- `device_rvalid_i`  in  NrDevices  response valid.
- `device_rdata_i`  in  NrDevices×DataWidth  read data.
- `device_err_i`  in  NrDevices  response error.
- `cfg_device_addr_base`  in  NrDevices×AddressWidth  base address per device.
- `cfg_device_addr_mask`  in  NrDevices×AddressWidth  match mask per device.

## Operation
- **Decode.** A host matches device d when `(addr & mask[d]) == base[d]`. The lowest matching d wins. No match selects the internal error target (index NrDevices).
- **Tracking.** The FIFO stores {host index, target} per granted transaction. A `cur_target` register holds the target of the most recent push.
- **Eligibility.** A requesting host is eligible when count < MaxOutstanding and either count == 0 or its target == `cur_target`. All in-flight transactions therefore share one target, which keeps responses in order.
- **Arbitration.** At most one grant per cycle, chosen among eligible hosts: fixed priority by default, round-robin under the macro (see Configuration).
- **Grant to a device.** Assert `device_req_o[d]` and forward the host's addr/we/be/wdata. Devices always accept. Push the FIFO entry and update `cur_target`.
- **Grant to the error target.** No device request is issued. Push the entry with target = NrDevices.
- **Device response.** When the FIFO is non-empty and the head target is a device d, `device_rvalid_i[d]` drives `host_rvalid_o[head.host]` and `device_err_i[d]` drives `host_err_o`, then the head is popped.
- **Error response.** When the head target is the error target, assert `host_rvalid_o[head.host]` and `host_err_o`, with `host_rdata_o` = 0, then pop.
- **Unexpected response.** `device_rvalid_i` for a device that is not the head target, or while the FIFO is empty, is ignored.
- **Full FIFO.** When count == MaxOutstanding, no grant is issued, even if a pop occurs in the same cycle.
- **Simultaneous push and pop** (count < Max): count is unchanged, both pointers advance, and pointers wrap modulo MaxOutstanding.

## Timing
- Grant and device request are combinational from `host_req_i` in the same cycle. A host holds its request until granted.
- Response routing is combinational from `device_rvalid_i`. Minimum device response latency is 1 cycle after the grant; any latency ≥1 is legal.
- The error response is asserted exactly 1 cycle after the grant if the FIFO was empty; otherwise it is asserted in the cycle it reaches the head.
- **Reset values:** all outputs 0 (`host_gnt_o`, `host_rvalid_o`, `host_err_o`, `host_rdata_o`, all `device_*_o`). FIFO is empty, `cur_target` = 0, round-robin pointer = NrHosts−1.
- Reset asserted mid-transaction discards all FIFO entries. Device responses arriving after reset deassertion are ignored.

## Configuration
- `BUS_RR_ARB_EN` defined: round-robin arbitration. The search starts at (last granted host + 1) mod NrHosts, and the pointer updates only on a grant.
- `BUS_RR_ARB_EN` undefined: fixed priority, lowest eligible host index wins. This matches the existing `bus` ordering.

## Test plan
- **Single read:** host 1 reads 0x100 (RAM, d0) and the device responds 1 cycle later with 0xDEADBEEF → `host_gnt_o` = 3'b010 in cycle 0, then `host_rvalid_o[1]` = 1 and `host_rdata_o` = 0xDEADBEEF in cycle 1.
- **Unmapped address:** host 2 accesses 0x40000 → granted, no `device_req_o` asserted, then `host_rvalid_o[2]` = 1 and `host_err_o` = 1 on the next cycle.
- **Outstanding and full:** MaxOutstanding = 4 and the device has 10-cycle latency; host 0 issues 5 back-to-back reads to d0 → 4 grants, 5th stalled until the first response, responses returned in order.
- **Target switch stall:** host 0 read to d0 is outstanding while host 1 requests d1 (0x20000) → host 1 is not granted until the d0 response pops, then granted in the following cycle.
- **Arbitration:** all 3 hosts request continuously with 1-cycle latency → without the macro, host 0 is granted every cycle; with `BUS_RR_ARB_EN`, grant order is 0, 1, 2, 0, 1, 2.
- **Reset mid-operation:** 2 transactions are outstanding and `rst_ni` is pulsed low → all outputs 0 immediately; late `device_rvalid_i` is ignored with no `host_rvalid_o`; the next request is granted normally.

Source files
------------

// File: rtl/bus_rr.sv
// bus_rr: multi-host / multi-device interconnect with address decode,
// single-target in-flight tracking and in-order response routing.
// Optional feature: define BUS_RR_ARB_EN for round-robin arbitration;
// without it, the lowest eligible host index wins (fixed priority).
module bus_rr #(
    parameter int NrHosts        = 3,
    parameter int NrDevices      = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic [NrDevices-1:0]              device_req_o,
    output logic [NrDevices*AddressWidth-1:0] device_addr_o,
    output logic [NrDevices-1:0]              device_we_o,
    output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
    output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
    input  logic [NrDevices-1:0]              device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
    input  logic [NrDevices-1:0]              device_err_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask
);

    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int TgtW  = $clog2(NrDevices + 1);
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam int BeW   = DataWidth / 8;

    // Target index NrDevices is the internal error responder.
    localparam logic [TgtW-1:0] ErrTgt  = TgtW'(NrDevices);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic [TgtW-1:0]  host_tgt [NrHosts];
    logic [NrHosts-1:0] eligible;
    logic             gnt_valid;
    logic [HostW-1:0] gnt_idx;
    logic [TgtW-1:0]  gnt_tgt;
    logic             push;
    logic             pop;

    logic [HostW-1:0] fifo_host_q [MaxOutstanding];
    logic [TgtW-1:0]  fifo_tgt_q  [MaxOutstanding];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [TgtW-1:0]  cur_target_q, cur_target_d;

    logic [HostW-1:0] head_host;
    logic [TgtW-1:0]  head_tgt;
    logic             fifo_empty;
    logic             fifo_has_room;
    logic [DataWidth-1:0] rsp_data;

    assign fifo_empty    = (count_q == '0);
    assign fifo_has_room = (count_q < MaxCnt);
    assign head_host     = fifo_host_q[rd_ptr_q];
    assign head_tgt      = fifo_tgt_q[rd_ptr_q];

    // Address decode per host; iterating downwards lets the lowest matching device win.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_tgt[h] = ErrTgt;
            for (int d = NrDevices - 1; d >= 0; d--) begin
                if ((host_addr_i[h*AddressWidth +: AddressWidth] &
                     cfg_device_addr_mask[d*AddressWidth +: AddressWidth]) ==
                    cfg_device_addr_base[d*AddressWidth +: AddressWidth]) begin
                    host_tgt[h] = TgtW'(d);
                end
            end
        end
    end

    // A host may only join the in-flight set if it targets the same destination,
    // which keeps responses in issue order without per-device reordering.
    // Gating with rst_ni keeps every output quiet while reset is held.
    always_comb begin
        eligible = '0;
        for (int h = 0; h < NrHosts; h++) begin
            eligible[h] = rst_ni && host_req_i[h] && fifo_has_room &&
                          (fifo_empty || (host_tgt[h] == cur_target_q));
        end
    end

`ifdef BUS_RR_ARB_EN
    logic [HostW-1:0] rr_ptr_q;

    // Round-robin pick: search starts one past the last granted host.
    always_comb begin
        int cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NrHosts; i++) begin
            cand = (int'(rr_ptr_q) + 1 + i) % NrHosts;
            if (!gnt_valid && eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = HostW'(cand);
            end
        end
    end

    // Round-robin pointer only moves when a grant is actually issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= HostW'(NrHosts - 1);
        end else if (gnt_valid) begin
            rr_ptr_q <= gnt_idx;
        end
    end
`else
    // Fixed priority pick: lowest eligible index wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (eligible[h]) begin
                gnt_valid = 1'b1;
                gnt_idx   = HostW'(h);
            end
        end
    end
`endif

    assign gnt_tgt = host_tgt[gnt_idx];
    assign push    = gnt_valid;

    // Grant and request forwarding; only the selected device sees the host's fields.
    always_comb begin
        host_gnt_o     = '0;
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        if (gnt_valid) begin
            host_gnt_o[gnt_idx] = 1'b1;
            for (int d = 0; d < NrDevices; d++) begin
                if (gnt_tgt == TgtW'(d)) begin
                    device_req_o[d] = 1'b1;
                    device_addr_o[d*AddressWidth +: AddressWidth] =
                        host_addr_i[int'(gnt_idx)*AddressWidth +: AddressWidth];
                    device_we_o[d] = host_we_i[gnt_idx];
                    device_be_o[d*BeW +: BeW] = host_be_i[int'(gnt_idx)*BeW +: BeW];
                    device_wdata_o[d*DataWidth +: DataWidth] =
                        host_wdata_i[int'(gnt_idx)*DataWidth +: DataWidth];
                end
            end
        end
    end

    // Response routing from the FIFO head; responses from other devices are dropped.
    always_comb begin
        pop           = 1'b0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        rsp_data      = '0;
        if (!fifo_empty) begin
            if (head_tgt == ErrTgt) begin
                pop                      = 1'b1;
                host_rvalid_o[head_host] = 1'b1;
                host_err_o[head_host]    = 1'b1;
            end else begin
                for (int d = 0; d < NrDevices; d++) begin
                    if ((head_tgt == TgtW'(d)) && device_rvalid_i[d]) begin
                        pop                      = 1'b1;
                        host_rvalid_o[head_host] = 1'b1;
                        host_err_o[head_host]    = device_err_i[d];
                        rsp_data                 = device_rdata_i[d*DataWidth +: DataWidth];
                    end
                end
            end
        end
    end

    assign host_rdata_o = {NrHosts{rsp_data}};

    // Next-state for pointers, occupancy and current target.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cur_target_d = cur_target_q;
        if (push) begin
            wr_ptr_d     = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            cur_target_d = gnt_tgt;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Tracking state; reset discards every in-flight entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cur_target_q <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_host_q[i] <= '0;
                fifo_tgt_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cur_target_q <= cur_target_d;
            if (push) begin
                fifo_host_q[wr_ptr_q] <= gnt_idx;
                fifo_tgt_q[wr_ptr_q]  <= gnt_tgt;
            end
        end
    end

endmodule
